// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between a BCD request source and the digit-serial adder controller.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: one shared single-digit BCD cell, LSD first,
// start/busy/done handshake with registered sum, carry-out and invalid-digit flag.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [KW-1:0] k_reg;
  logic          carry_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic [W-1:0]  sum_next;
  logic          cout_reg;
  logic          err_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [3:0]    a_digits [DIGITS];
  logic [3:0]    b_digits [DIGITS];
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [4:0]    cell_raw;
  logic [3:0]    cell_s;
  logic          cell_cout;
  logic          dig_invalid;

  // Split latched operands into digits and merge the cell result back into slot k.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      localparam logic [KW-1:0] GI_K = KW'(gi);
      assign a_digits[gi] = a_reg[4*gi +: 4];
      assign b_digits[gi] = b_reg[4*gi +: 4];
      assign sum_next[4*gi +: 4] = (k_reg == GI_K) ? cell_s : sum_reg[4*gi +: 4];
    end
  endgenerate

  assign a_dig       = a_digits[k_reg];
  assign b_dig       = b_digits[k_reg];
  assign dig_invalid = (a_dig > 4'd9) || (b_dig > 4'd9);

  // Single-digit BCD adder cell; +6 correction folds a binary 10..19 back into BCD.
  always_comb begin
    cell_raw  = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_reg};
    cell_cout = (cell_raw > 5'd9);
    cell_s    = cell_cout ? (cell_raw[3:0] + 4'd6) : cell_raw[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_ADD: begin
          sum_reg   <= sum_next;
          carry_reg <= cell_cout;
          if (dig_invalid) begin
            err_reg <= 1'b1;
          end
          if (k_reg == K_LAST) begin
            cout_reg  <= cell_cout;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
            k_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_ADD;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.err  = err_reg;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed vector table, multi-cycle corner sequences,
// and random operations checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst;
  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
    bit           chk_sum;
    bit           b2b;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: operands as decimal integers, add, split back into digits.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                output logic [W-1:0] s, output logic co, output logic e);
    longint va, vb, p, t;
    logic [3:0] dx, dy;
    va = 0; vb = 0; p = 1; e = 1'b0; s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dx = x[4*i +: 4];
      dy = y[4*i +: 4];
      if (dx > 4'd9 || dy > 4'd9) e = 1'b1;
      va += longint'(dx) * p;
      vb += longint'(dy) * p;
      p  *= 10;
    end
    t  = va + vb + longint'(c);
    co = (t >= p);
    t  = t % p;
    for (int i = 0; i < DIGITS; i++) begin
      s[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  // Issue one operation and wait for its done pulse. With b2b=1 the caller is
  // sitting at the negedge of a DONE cycle and start goes in with no idle gap.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input bit b2b, output logic [W-1:0] rs, output logic rc,
                       output logic re);
    int  lat;
    bit  busy_ok;
    if (!b2b) begin
      @(negedge clk);
      chk("done_low_before_start", {63'd0, bus.done}, 64'd0);
    end
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    bus.cin   = tcin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    @(negedge clk);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < DIGITS + 6) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("busy_during_add", {63'd0, busy_ok}, 64'd1);
    chk("done_latency", 64'(lat), 64'(DIGITS + 1));
    chk("busy_low_at_done", {63'd0, bus.busy}, 64'd0);
    rs = bus.sum;
    rc = bus.cout;
    re = bus.err;
    $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d lat=%0d",
             ta, tb, tcin, rs, rc, re, lat);
  endtask

  initial begin
    logic [W-1:0] rs, es;
    logic         rc, re, ec, ee;
    logic [W-1:0] ra, rb;
    logic         rcin;
    int           done_cnt;
    logic [W-1:0] cap_sum;
    logic         cap_cout;
    bit           b2b;

    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_sum",  64'(bus.sum), 64'd0);
    chk("rst_cout", {63'd0, bus.cout}, 64'd0);
    chk("rst_err",  {63'd0, bus.err}, 64'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].b2b, rs, rc, re);
      if (tbl[i].chk_sum) begin
        chk($sformatf("tbl%0d_sum", i),  64'(rs), 64'(tbl[i].exp_sum));
        chk($sformatf("tbl%0d_cout", i), {63'd0, rc}, {63'd0, tbl[i].exp_cout});
      end
      chk($sformatf("tbl%0d_err", i), {63'd0, re}, {63'd0, tbl[i].exp_err});
    end

    // Start during the second busy cycle must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h9999; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0; cap_sum = '0; cap_cout = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) begin
        done_cnt++;
        cap_sum  = bus.sum;
        cap_cout = bus.cout;
      end
      @(negedge clk);
    end
    $display("op a=1111 b=2222 (ignored 9999+9999) -> sum=%h cout=%0d dones=%0d",
             cap_sum, cap_cout, done_cnt);
    chk("ign_done_count", 64'(done_cnt), 64'd1);
    chk("ign_sum", 64'(cap_sum), 64'h3333);
    chk("ign_cout", {63'd0, cap_cout}, 64'd0);

    // Reset during the second ADD cycle
    bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.done}, 64'd0);
    chk("midrst_sum",  64'(bus.sum), 64'd0);
    chk("midrst_cout", {63'd0, bus.cout}, 64'd0);
    chk("midrst_err",  {63'd0, bus.err}, 64'd0);
    done_cnt = 0;
    for (int c = 0; c < DIGITS + 3; c++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    $display("op a=4321 b=1111 aborted by rst -> dones=%0d", done_cnt);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    do_op(16'h0005, 16'h0005, 1'b0, 1'b0, rs, rc, re);
    chk("postrst_sum", 64'(rs), 64'h0010);
    chk("postrst_cout", {63'd0, rc}, 64'd0);

    // Random operations against the decimal model
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 4) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      rcin = 1'($urandom);
      b2b  = (i > 0) && ($urandom_range(0, 1) == 1);
      model(ra, rb, rcin, es, ec, ee);
      do_op(ra, rb, rcin, b2b, rs, rc, re);
      chk($sformatf("rnd%0d_err", i), {63'd0, re}, {63'd0, ee});
      if (!ee) begin
        chk($sformatf("rnd%0d_sum", i),  64'(rs), 64'(es));
        chk($sformatf("rnd%0d_cout", i), {63'd0, rc}, {63'd0, ec});
      end
    end

    @(negedge clk);
    chk("final_done_low", {63'd0, bus.done}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial controller that adds two DIGITS-wide packed BCD operands.
It reuses one single-digit BCD adder cell (4-bit a, 4-bit b, cin -> 4-bit s, cout) across cycles, least-significant digit first.
It provides a start/busy/done handshake, a registered multi-digit result, carry-out, and an invalid-digit error flag.
It sits between a request source (e.g. a keypad/display path) and the shared digit adder, and is the sequencer for that cell.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only when the controller is ready (IDLE or DONE).
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD, same layout as a.
cin  input  1  carry into digit 0.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when sum/cout/err become valid.
sum  output  4*DIGITS  registered BCD result, same layout as a.
cout  output  1  carry out of the most-significant digit.
err  output  1  high if any digit of the latched a or b was > 9.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, sum=0, cout=0, err=0, state=IDLE, digit index=0, internal carry=0, operand registers=0.
- rst has priority over every other input, including mid-operation. The partial result is discarded, and the controller reaches IDLE at the next edge.
- States:
  - IDLE: wait for start.
  - ADD: one digit per cycle.
  - DONE: one-cycle result-valid state.
- IDLE/DONE with start=1 at edge E:
  - latch a, b, and cin into the internal carry;
  - clear sum, cout, err;
  - set digit index k=0, busy=1;
  - go to ADD.
- DONE with start=0: go to IDLE. sum, cout and err hold their values.
- ADD, each edge:
  - Feed digit k of the latched a and b, plus the internal carry, to the adder cell.
  - Write the cell's s into sum digit k. Write the cell's cout into the internal carry.
  - If either input digit k > 9, set err=1 (sticky until the next accepted start). The cell output is still written unchanged; it is undefined for invalid digits.
  - If k == DIGITS-1: set cout to the cell cout, busy=0, done=1, and go to DONE. Otherwise k=k+1.
- done is high only in the DONE state, for exactly one cycle per operation.
- Latency: start sampled at edge E gives busy=1 after E, and done=1 after edge E+DIGITS. The next start can be accepted at edge E+DIGITS+1 (back-to-back throughput of DIGITS+1 cycles).
- start while busy=1 is ignored. No queuing, and the latched operands are unaffected.
- a, b and cin may change freely after the accepting edge; only the latched copies are used.
- The adder cell is purely combinational. All results are registered, and no output is combinationally dependent on inputs.
- Width of k: clog2(DIGITS), with a minimum of 1 bit. The last-digit compare is against DIGITS-1 exactly; no wrap beyond it.
- DIGITS=1: a single ADD cycle, then DONE.

Test Plan:
- DIGITS=4. Reset, then start with a=0x1234, b=0x5678, cin=0:
  - busy for 4 cycles;
  - done after the 4th edge with sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0: sum=0x0000, cout=1. Then a=0x5000, b=0x5000, cin=1: sum=0x0001, cout=1. Issue these back-to-back, with start asserted in the DONE cycle; the second operation must be accepted with no idle gap.
- a=0x00A0, b=0x0000: err=1 at done. A following valid operation (a=0x0001, b=0x0002) clears err and gives sum=0x0003.
- start with a=0x1111, b=0x2222, then pulse start with a=0x9999, b=0x9999 on the second busy cycle: result is 0x3333, cout=0. The second request is ignored, and exactly one done pulse is seen.
- rst asserted during the 2nd ADD cycle of a=0x4321, b=0x1111:
  - all outputs are 0 after the edge;
  - no done pulse occurs;
  - a new start (a=0x0005, b=0x0005) then gives sum=0x0010, cout=0.
